// File: rtl/register_sync_receiver_pkg.sv
// rtl/register_sync_receiver_pkg.sv - shared register-sync types and defaults
// Holds both the receiver state machine encoding and the manager's state constants.
package register_sync_receiver_pkg;

  localparam int DEFAULT_REGISTER_AMOUNT = 32;
  localparam int DEFAULT_REGISTER_WIDTH  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } sync_state_e;

  typedef enum logic [1:0] {
    MGR_IDLE      = 2'd0,
    MGR_COLLECT   = 2'd1,
    MGR_MERGE     = 2'd2,
    MGR_BROADCAST = 2'd3
  } mgr_state_e;

endpackage

// File: rtl/register_sync_receiver_edge_detector.sv
// rtl/register_sync_receiver_edge_detector.sv - registered rising-edge detector
// The history flop resets high so a level already asserted at reset release is not an edge.
module edge_detector (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b1;
      rise  <= 1'b0;
    end else begin
      sig_q <= sig;
      rise  <= sig & ~sig_q;
    end
  end

endmodule

// File: rtl/register_sync_receiver.sv
// rtl/register_sync_receiver.sv - local register file refreshed from the manager's merged image
// A sync edge walks indices 1..N-1 copying the live image; core writes always take priority.
module register_sync_receiver
  import register_sync_receiver_pkg::*;
#(
  parameter int REGISTER_AMOUNT = DEFAULT_REGISTER_AMOUNT,
  parameter int REGISTER_WIDTH  = DEFAULT_REGISTER_WIDTH,
  parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      synchronization_processor,
  input  logic [REGISTER_WIDTH-1:0] registers_renew [0:REGISTER_AMOUNT-1],
  input  logic                      core_wr_en,
  input  logic [REG_CTN_WIDTH-1:0]  core_wr_addr,
  input  logic [REGISTER_WIDTH-1:0] core_wr_data,
  input  logic [REG_CTN_WIDTH-1:0]  core_rd_addr_1,
  input  logic [REG_CTN_WIDTH-1:0]  core_rd_addr_2,
  output logic [REGISTER_WIDTH-1:0] core_rd_data_1,
  output logic [REGISTER_WIDTH-1:0] core_rd_data_2,
  output logic [REGISTER_WIDTH-1:0] processor_registers [0:REGISTER_AMOUNT-1],
  output logic                      sync_busy,
  output logic                      sync_done
);

  localparam logic [REG_CTN_WIDTH-1:0] FIRST_IDX = REG_CTN_WIDTH'(1);
  localparam logic [REG_CTN_WIDTH-1:0] LAST_IDX  = REG_CTN_WIDTH'(REGISTER_AMOUNT - 1);

  sync_state_e               state;
  sync_state_e               next_state;
  logic [REG_CTN_WIDTH-1:0]  idx;
  logic                      sync_rise;
  logic                      copy_en;
  logic [REGISTER_WIDTH-1:0] regs [0:REGISTER_AMOUNT-1];

  edge_detector u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (synchronization_processor),
    .rise  (sync_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A fresh edge in any state (re)starts the copy from index 1.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = sync_rise ? COPY : IDLE;
      COPY:    next_state = sync_rise ? COPY : ((idx == LAST_IDX) ? DONE : COPY);
      DONE:    next_state = sync_rise ? COPY : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    sync_busy = 1'b0;
    sync_done = 1'b0;
    copy_en   = 1'b0;
    case (state)
      COPY: begin
        sync_busy = 1'b1;
        copy_en   = 1'b1;
      end
      DONE: begin
        sync_busy = 1'b1;
        sync_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= FIRST_IDX;
    end else if (copy_en && !sync_rise && (idx != LAST_IDX)) begin
      idx <= idx + FIRST_IDX;
    end else begin
      idx <= FIRST_IDX;
    end
  end

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGISTER_AMOUNT; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < REGISTER_AMOUNT; i++) begin
        if (core_wr_en && (core_wr_addr == REG_CTN_WIDTH'(i))) begin
          regs[i] <= core_wr_data;
        end else if (copy_en && (idx == REG_CTN_WIDTH'(i))) begin
          regs[i] <= registers_renew[i];
        end
      end
    end
  end

  assign core_rd_data_1 = (core_rd_addr_1 == '0) ? '0 : regs[core_rd_addr_1];
  assign core_rd_data_2 = (core_rd_addr_2 == '0) ? '0 : regs[core_rd_addr_2];

  always_comb begin
    processor_registers[0] = '0;
    for (int i = 1; i < REGISTER_AMOUNT; i++) begin
      processor_registers[i] = regs[i];
    end
  end

endmodule

// File: doc/register_sync_receiver.md
REGISTER_SYNC_RECEIVER -- requirements
Module: register_sync_receiver

Interface
REQ-001 SHALL have parameter REGISTER_AMOUNT, default 32, number of architectural registers.
REQ-002 SHALL have parameter REGISTER_WIDTH, default 64, bits per register.
REQ-003 SHALL have parameter REG_CTN_WIDTH, default $clog2(REGISTER_AMOUNT), register index width.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 synchronization_processor  input  1  sync request from the register manager; rising edge starts a copy.
REQ-007 registers_renew  input  REGISTER_WIDTH x [0:REGISTER_AMOUNT-1]  merged register image from the manager.
REQ-008 core_wr_en / core_wr_addr / core_wr_data  input  1 / REG_CTN_WIDTH / REGISTER_WIDTH  core write port.
REQ-009 core_rd_addr_1, core_rd_addr_2  input  REG_CTN_WIDTH each  core read addresses.
REQ-010 core_rd_data_1, core_rd_data_2  output  REGISTER_WIDTH each  combinational read data.
REQ-011 processor_registers  output  REGISTER_WIDTH x [0:REGISTER_AMOUNT-1]  full local register file, returned to the manager.
REQ-012 sync_busy  output  1  high while a copy is in progress; the core stalls on it.
REQ-013 sync_done  output  1  one-cycle pulse when a copy completes.

Function
REQ-014 States SHALL be IDLE, COPY and DONE.
REQ-015 IDLE->COPY SHALL occur on the cycle after a detected rising edge of synchronization_processor; index counter loads 1.
REQ-016 In COPY, each cycle SHALL write registers_renew[idx] into local register idx, then increment idx.
REQ-017 Index 0 SHALL never be written and SHALL always read as zero.
REQ-018 COPY->DONE SHALL occur after idx = REGISTER_AMOUNT-1 is written: 31 COPY cycles at default parameters.
REQ-019 DONE SHALL assert sync_done for exactly one cycle, then return to IDLE.
REQ-020 sync_busy SHALL be high in COPY and DONE, and low in IDLE.
REQ-021 Latency from the sync rising edge to the sync_done pulse SHALL be REGISTER_AMOUNT+1 cycles (33 at default).
REQ-022 registers_renew SHALL be sampled live each COPY cycle; no snapshot is taken.
REQ-023 A core write in IDLE SHALL update core_wr_addr, except address 0, at the next edge.
REQ-024 If a core write and a copy target the same index in the same cycle, the core write SHALL win.
REQ-025 A core write in COPY or DONE to another index SHALL still take effect.
REQ-026 A new sync rising edge during COPY SHALL restart the copy at idx 1 on the next cycle; no sync_done is issued for the aborted pass.
REQ-027 A new sync rising edge during DONE SHALL still emit sync_done, then enter COPY with idx 1.
REQ-028 A level held high on synchronization_processor SHALL trigger exactly one copy.
REQ-029 Reads SHALL return current register contents combinationally, with no write bypass; address 0 returns 0.
REQ-030 processor_registers SHALL mirror the register file, with entry 0 tied to 0.

Reset
REQ-031 Asserting rst_n low SHALL, asynchronously: clear all registers to 0, set state IDLE, set idx to 1, and drive sync_busy=0, sync_done=0.
REQ-032 Reset asserted mid-COPY SHALL abort the copy; no sync_done follows deassertion.
REQ-033 The edge detector SHALL reset so that synchronization_processor high at deassertion causes no spurious start.

Structure
REQ-034 The state enum (IDLE/COPY/DONE) and the REGISTER_AMOUNT/REGISTER_WIDTH defaults SHALL live in the shared package, alongside the manager's state constants.
REQ-035 Rising-edge detection SHALL instantiate the existing edge_detector sub-module; no other sub-modules.

Verification
REQ-036 Reset, then pulse sync with registers_renew[i]=i*0x11 -> sync_busy high 32 cycles; sync_done pulses at cycle 33; reg[5]=0x55; reg[0]=0.
REQ-037 During COPY, core writes 0xDEAD to reg 7 in the cycle idx=7 -> reg 7 = 0xDEAD after done.
REQ-038 Second sync edge when idx=20 -> copy restarts at 1; single sync_done 33 cycles after the second edge.
REQ-039 Hold sync high 100 cycles -> exactly one sync_done.
REQ-040 Assert rst_n at idx=10 -> all registers 0; sync_busy=0; no sync_done after release.
REQ-041 Core write reg 0 = 0xFFFF in IDLE -> core_rd_data_1 at address 0 reads 0.
